// File: rtl/rv32_pkg.sv
// Shared RV32 encodings, funct constants, execute-stage FSM states and immediate extraction.
// Immediate helpers return 32 bits; the datapath is RV32 only.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} ex_state_t;

  function automatic logic [31:0] imm_i(input logic [31:0] iw);
    return {{20{iw[31]}}, iw[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] iw);
    return {{20{iw[31]}}, iw[31:25], iw[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] iw);
    return {{19{iw[31]}}, iw[31], iw[7], iw[30:25], iw[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] iw);
    return {iw[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] iw);
    return {{11{iw[31]}}, iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/rv32_muldiv_iter.sv
// Iterative M-extension unit: magnitude shift-add multiply and restoring divide with
// sign fix-up on the way out. Retires MD_RADIX_2 bits per cycle.
module rv32_muldiv_iter
  import rv32_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MD_RADIX_2 = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            last,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int ITER = XLEN / MD_RADIX_2;
  localparam int CW   = $clog2(ITER + 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d, a_q, a_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d, dz_q, dz_d;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn = (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
    b_sgn = (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    a_neg = a_sgn & a[XLEN-1];
    b_neg = b_sgn & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // hi:lo is the product accumulator for multiply and remainder:quotient for divide
  always_comb begin : iterate
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    cnt_d  = cnt_q;
    done_d = done_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    dvs_d  = dvs_q;
    a_d    = a_q;
    op_d   = op_q;
    neg_d  = neg_q;
    dz_d   = dz_q;
    sum    = '0;
    rem_sh = '0;
    if (kill) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (start) begin
      cnt_d  = CW'(ITER);
      done_d = 1'b0;
      op_d   = op;
      a_d    = a;
      hi_d   = '0;
      lo_d   = op[2] ? a_mag : b_mag;
      dvs_d  = op[2] ? b_mag : a_mag;
      neg_d  = (op == F3_REM) ? a_neg : (a_neg ^ b_neg);
      dz_d   = (b == '0);
    end else if (cnt_q != '0) begin
      for (int i = 0; i < MD_RADIX_2; i++) begin
        if (op_q[2]) begin
          rem_sh = {hi_d, lo_d[XLEN-1]};
          lo_d   = {lo_d[XLEN-2:0], 1'b0};
          if (rem_sh >= {1'b0, dvs_q}) begin
            hi_d    = XLEN'(rem_sh - {1'b0, dvs_q});
            lo_d[0] = 1'b1;
          end else begin
            hi_d = rem_sh[XLEN-1:0];
          end
        end else begin
          sum  = {1'b0, hi_d} + (lo_d[0] ? {1'b0, dvs_q} : '0);
          hi_d = sum[XLEN:1];
          lo_d = {sum[0], lo_d[XLEN-1:1]};
        end
      end
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dvs_q  <= '0;
      a_q    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dvs_q  <= dvs_d;
      a_q    <= a_d;
      op_q   <= op_d;
      neg_q  <= neg_d;
      dz_q   <= dz_d;
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = neg_q ? -hi_q : hi_q;

  // Division by zero bypasses the sign fix-up; MIN/-1 falls out of the magnitude path
  always_comb begin
    result = '0;
    case (op_q)
      F3_MUL:                        result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               result = dz_q ? '1 : quo_fix;
      default:                       result = dz_q ? a_q : rem_fix;
    endcase
  end

  assign busy = (cnt_q != '0);
  assign last = (cnt_q == CW'(1));
  assign done = done_q;

endmodule

// File: rtl/rv32_ex_stage_mc.sv
// RV32 execute stage with valid/ready handshake, flush, branch resolution and forwarding.
// Define RV32_MULDIV_EN to route M-extension ops through the iterative mul/div unit.
module rv32_ex_stage_mc
  import rv32_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int MD_RADIX_2 = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [31:0]       iw_in,
  input  logic [XLEN-1:0]   rs1_data_in,
  input  logic [XLEN-1:0]   rs2_data_in,
  input  logic              wb_en_in,
  input  logic [REG_AW-1:0] wb_reg_in,
  input  logic              flush_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_out,
  output logic [31:0]       iw_out,
  output logic [XLEN-1:0]   pc_out,
  output logic              wb_en_out,
  output logic [REG_AW-1:0] wb_reg_out,
  output logic              br_taken_out,
  output logic [XLEN-1:0]   br_target_out,
  output logic              illegal_out,
  output logic              df_ex_enable,
  output logic [REG_AW-1:0] df_ex_reg,
  output logic [XLEN-1:0]   df_ex_data,
  output logic              df_ex_pending
);

  function automatic logic [XLEN-1:0] alu_calc(input logic [2:0] f3, input logic alt,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic [4:0]             sh;
    a_s = a;
    sh  = b[4:0];
    case (f3)
      F3_ADD:  alu_calc = alt ? (a - b) : (a + b);
      F3_SLL:  alu_calc = a << sh;
      F3_SLT:  alu_calc = XLEN'($signed(a) < $signed(b));
      F3_SLTU: alu_calc = XLEN'(a < b);
      F3_XOR:  alu_calc = a ^ b;
      F3_SR:   alu_calc = alt ? XLEN'(a_s >>> sh) : (a >> sh);
      F3_OR:   alu_calc = a | b;
      default: alu_calc = a & b;
    endcase
  endfunction

  function automatic logic br_cond(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    case (f3)
      F3_BEQ:  br_cond = (a == b);
      F3_BNE:  br_cond = (a != b);
      F3_BLT:  br_cond = ($signed(a) < $signed(b));
      F3_BGE:  br_cond = ($signed(a) >= $signed(b));
      F3_BLTU: br_cond = (a < b);
      F3_BGEU: br_cond = (a >= b);
      default: br_cond = 1'b0;
    endcase
  endfunction

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  assign opcode = iw_in[6:0];
  assign f3     = iw_in[14:12];
  assign f7     = iw_in[31:25];

  ex_state_t state_q;
  logic      rdy_q;
  logic      free, xfer, load_alu, load_md;

  logic [XLEN-1:0] ex_res, ex_tgt;
  logic            ex_br, ex_ill, ex_is_m;

  // Stage p0: decode and single-cycle ALU / branch resolution
  always_comb begin
    ex_res  = '0;
    ex_tgt  = '0;
    ex_br   = 1'b0;
    ex_ill  = 1'b0;
    ex_is_m = 1'b0;
    case (opcode)
      OP_R: begin
        if (f7 == F7_MULDIV) begin
`ifdef RV32_MULDIV_EN
          ex_is_m = 1'b1;
`else
          ex_ill  = 1'b1;
`endif
        end else if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) begin
          ex_res = alu_calc(f3, f7[5], rs1_data_in, rs2_data_in);
        end else begin
          ex_ill = 1'b1;
        end
      end
      OP_IMM: begin
        if ((f3 == F3_SLL && f7 != F7_BASE) ||
            (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT))
          ex_ill = 1'b1;
        else
          ex_res = alu_calc(f3, (f3 == F3_SR) && f7[5], rs1_data_in, XLEN'(imm_i(iw_in)));
      end
      OP_LOAD: begin
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ex_ill = 1'b1;
        else ex_res = rs1_data_in + XLEN'(imm_i(iw_in));
      end
      OP_STORE: begin
        if (f3 > 3'd2) ex_ill = 1'b1;
        else ex_res = rs1_data_in + XLEN'(imm_s(iw_in));
      end
      OP_BRANCH: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          ex_ill = 1'b1;
        end else begin
          ex_br  = br_cond(f3, rs1_data_in, rs2_data_in);
          ex_tgt = pc_in + XLEN'(imm_b(iw_in));
        end
      end
      OP_JAL: begin
        ex_res = pc_in + XLEN'(4);
        ex_br  = 1'b1;
        ex_tgt = pc_in + XLEN'(imm_j(iw_in));
      end
      OP_JALR: begin
        if (f3 != 3'd0) begin
          ex_ill = 1'b1;
        end else begin
          ex_res = pc_in + XLEN'(4);
          ex_br  = 1'b1;
          ex_tgt = (rs1_data_in + XLEN'(imm_i(iw_in))) & ~XLEN'(1);
        end
      end
      OP_LUI:   ex_res = XLEN'(imm_u(iw_in));
      OP_AUIPC: ex_res = pc_in + XLEN'(imm_u(iw_in));
      default:  ex_ill = 1'b1;
    endcase
  end

  logic              vld_p1_q, vld_p1_d, br_p1_q, br_p1_d, ill_p1_q, ill_p1_d;
  logic              wb_en_p1_q, wb_en_p1_d;
  logic [XLEN-1:0]   res_p1_q, res_p1_d, tgt_p1_q, tgt_p1_d, pc_p1_q, pc_p1_d;
  logic [31:0]       iw_p1_q, iw_p1_d;
  logic [REG_AW-1:0] wb_reg_p1_q, wb_reg_p1_d;

  assign free     = !vld_p1_q | out_ready;
  assign in_ready = rdy_q & (state_q == IDLE) & free & !flush_in;
  assign xfer     = in_valid & in_ready;
  assign load_alu = xfer & !ex_is_m;

`ifdef RV32_MULDIV_EN
  ex_state_t         state_d;
  logic              md_busy, md_last, md_done;
  logic [XLEN-1:0]   md_result;
  logic [XLEN-1:0]   md_pc_q, md_pc_d;
  logic [31:0]       md_iw_q, md_iw_d;
  logic              md_wb_en_q, md_wb_en_d;
  logic [REG_AW-1:0] md_wb_reg_q, md_wb_reg_d;

  rv32_muldiv_iter #(
    .XLEN       (XLEN),
    .MD_RADIX_2 (MD_RADIX_2)
  ) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (xfer & ex_is_m),
    .kill    (flush_in),
    .op      (f3),
    .a       (rs1_data_in),
    .b       (rs2_data_in),
    .busy    (md_busy),
    .last    (md_last),
    .done    (md_done),
    .result  (md_result)
  );

  always_comb begin
    state_d = state_q;
    load_md = 1'b0;
    case (state_q)
      IDLE: if (xfer && ex_is_m) state_d = BUSY;
      BUSY: begin
        if (flush_in)     state_d = IDLE;
        else if (md_last) state_d = DONE;
      end
      DONE: begin
        if (flush_in) begin
          state_d = IDLE;
        end else if (free && md_done) begin
          load_md = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    md_pc_d     = md_pc_q;
    md_iw_d     = md_iw_q;
    md_wb_en_d  = md_wb_en_q;
    md_wb_reg_d = md_wb_reg_q;
    if (xfer && ex_is_m) begin
      md_pc_d     = pc_in;
      md_iw_d     = iw_in;
      md_wb_en_d  = wb_en_in;
      md_wb_reg_d = wb_reg_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      md_pc_q     <= '0;
      md_iw_q     <= '0;
      md_wb_en_q  <= 1'b0;
      md_wb_reg_q <= '0;
    end else begin
      state_q     <= state_d;
      md_pc_q     <= md_pc_d;
      md_iw_q     <= md_iw_d;
      md_wb_en_q  <= md_wb_en_d;
      md_wb_reg_q <= md_wb_reg_d;
    end
  end

  assign df_ex_pending = md_busy | (state_q == DONE);
`else
  assign state_q       = IDLE;
  assign load_md       = 1'b0;
  assign df_ex_pending = 1'b0;
`endif

  // Stage p1: output register, held while the memory stage stalls
  always_comb begin
    vld_p1_d    = vld_p1_q;
    br_p1_d     = br_p1_q;
    ill_p1_d    = ill_p1_q;
    wb_en_p1_d  = wb_en_p1_q;
    res_p1_d    = res_p1_q;
    tgt_p1_d    = tgt_p1_q;
    pc_p1_d     = pc_p1_q;
    iw_p1_d     = iw_p1_q;
    wb_reg_p1_d = wb_reg_p1_q;
    if (flush_in) begin
      vld_p1_d = 1'b0;
      br_p1_d  = 1'b0;
    end else if (load_alu) begin
      vld_p1_d    = 1'b1;
      br_p1_d     = ex_br;
      ill_p1_d    = ex_ill;
      wb_en_p1_d  = wb_en_in & !ex_ill;
      res_p1_d    = ex_res;
      tgt_p1_d    = ex_tgt;
      pc_p1_d     = pc_in;
      iw_p1_d     = iw_in;
      wb_reg_p1_d = wb_reg_in;
    end else if (load_md) begin
      vld_p1_d    = 1'b1;
      br_p1_d     = 1'b0;
      ill_p1_d    = 1'b0;
`ifdef RV32_MULDIV_EN
      wb_en_p1_d  = md_wb_en_q;
      res_p1_d    = md_result;
      pc_p1_d     = md_pc_q;
      iw_p1_d     = md_iw_q;
      wb_reg_p1_d = md_wb_reg_q;
`endif
      tgt_p1_d    = '0;
    end else if (out_ready) begin
      vld_p1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q       <= 1'b0;
      vld_p1_q    <= 1'b0;
      br_p1_q     <= 1'b0;
      ill_p1_q    <= 1'b0;
      wb_en_p1_q  <= 1'b0;
      res_p1_q    <= '0;
      tgt_p1_q    <= '0;
      pc_p1_q     <= '0;
      iw_p1_q     <= '0;
      wb_reg_p1_q <= '0;
    end else begin
      rdy_q       <= 1'b1;
      vld_p1_q    <= vld_p1_d;
      br_p1_q     <= br_p1_d;
      ill_p1_q    <= ill_p1_d;
      wb_en_p1_q  <= wb_en_p1_d;
      res_p1_q    <= res_p1_d;
      tgt_p1_q    <= tgt_p1_d;
      pc_p1_q     <= pc_p1_d;
      iw_p1_q     <= iw_p1_d;
      wb_reg_p1_q <= wb_reg_p1_d;
    end
  end

  assign out_valid     = vld_p1_q;
  assign alu_out       = res_p1_q;
  assign iw_out        = iw_p1_q;
  assign pc_out        = pc_p1_q;
  assign wb_en_out     = wb_en_p1_q;
  assign wb_reg_out    = wb_reg_p1_q;
  assign br_taken_out  = br_p1_q & vld_p1_q;
  assign br_target_out = tgt_p1_q;
  assign illegal_out   = ill_p1_q;
  assign df_ex_enable  = vld_p1_q & wb_en_p1_q & (wb_reg_p1_q != '0);
  assign df_ex_reg     = wb_reg_p1_q;
  assign df_ex_data    = res_p1_q;

endmodule

// File: tb/tb_rv32_ex_stage_mc.sv
// Directed-vector bench for rv32_ex_stage_mc; M-extension vectors follow RV32_MULDIV_EN.
module tb_rv32_ex_stage_mc;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, wb_en_in, flush_in, out_valid, out_ready;
  logic [31:0] pc_in, iw_in, rs1_data_in, rs2_data_in;
  logic [4:0]  wb_reg_in, wb_reg_out, df_ex_reg;
  logic [31:0] alu_out, iw_out, pc_out, br_target_out, df_ex_data;
  logic        wb_en_out, br_taken_out, illegal_out, df_ex_enable, df_ex_pending;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  rv32_ex_stage_mc dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .iw_in(iw_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .wb_en_in(wb_en_in), .wb_reg_in(wb_reg_in), .flush_in(flush_in),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out), .iw_out(iw_out),
    .pc_out(pc_out), .wb_en_out(wb_en_out), .wb_reg_out(wb_reg_out),
    .br_taken_out(br_taken_out), .br_target_out(br_target_out), .illegal_out(illegal_out),
    .df_ex_enable(df_ex_enable), .df_ex_reg(df_ex_reg), .df_ex_data(df_ex_data),
    .df_ex_pending(df_ex_pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] iw, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] rd);
    in_valid    = 1'b1;
    iw_in       = iw;
    pc_in       = pc;
    rs1_data_in = r1;
    rs2_data_in = r2;
    wb_en_in    = 1'b1;
    wb_reg_in   = rd;
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [6:0] op);
    return {imm, 5'd1, f3, 5'd3, op};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_type(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

`ifdef RV32_MULDIV_EN
  task automatic md_run(input string tag, input logic [2:0] f3, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] exp);
    int lat;
    issue(r_type(7'b0000001, f3), 32'h400, r1, r2, 5'd9);
    tick();
    in_valid = 1'b0;
    chk({tag, "_pending"}, {31'd0, df_ex_pending}, 32'd1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (!out_valid) begin
        tick();
        lat = n;
      end
    end
    chk({tag, "_latency"}, lat, 32'd33);
    chk({tag, "_result"}, alu_out, exp);
    chk({tag, "_wbreg"}, {27'd0, wb_reg_out}, 32'd9);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic seen;
    reset_n = 1'b0; in_valid = 1'b0; iw_in = '0; pc_in = '0; rs1_data_in = '0;
    rs2_data_in = '0; wb_en_in = 1'b0; wb_reg_in = '0; flush_in = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_pending", {31'd0, df_ex_pending}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready_early", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    issue(r_type(7'h00, 3'b000), 32'h0, 32'd5, 32'd7, 5'd5);
    tick();
    chk("add_res", alu_out, 32'd12);
    chk("add_vld", {31'd0, out_valid}, 32'd1);
    chk("add_in_ready", {31'd0, in_ready}, 32'd1);
    issue(r_type(7'h20, 3'b000), 32'h4, 32'd3, 32'd5, 5'd6);
    tick();
    chk("sub_res", alu_out, 32'hFFFF_FFFE);
    chk("sub_wbreg", {27'd0, wb_reg_out}, 32'd6);
    chk("sub_df_en", {31'd0, df_ex_enable}, 32'd1);
    chk("sub_df_data", df_ex_data, 32'hFFFF_FFFE);

    issue(r_type(7'h20, 3'b101), 32'h8, 32'h8000_0000, 32'h21, 5'd1);
    tick();
    chk("sra_res", alu_out, 32'hC000_0000);
    issue(r_type(7'h00, 3'b011), 32'hC, 32'd1, 32'hFFFF_FFFF, 5'd1);
    tick();
    chk("sltu_res", alu_out, 32'd1);
    issue(r_type(7'h00, 3'b010), 32'h10, 32'd1, 32'hFFFF_FFFF, 5'd1);
    tick();
    chk("slt_res", alu_out, 32'd0);
    issue(i_type(12'hFFD, 3'b000, 7'b0010011), 32'h14, 32'd10, 32'd0, 5'd1);
    tick();
    chk("addi_neg", alu_out, 32'd7);

    issue(b_type(13'd16, 3'b101), 32'h100, 32'hFFFF_FFFF, 32'd1, 5'd0);
    tick();
    chk("bge_taken", {31'd0, br_taken_out}, 32'd0);
    chk("bge_alu", alu_out, 32'd0);
    issue(b_type(13'd16, 3'b100), 32'h100, 32'hFFFF_FFFF, 32'd1, 5'd0);
    tick();
    chk("blt_taken", {31'd0, br_taken_out}, 32'd1);
    chk("blt_target", br_target_out, 32'h110);
    issue(i_type(12'h000, 3'b000, 7'b1100111), 32'h100, 32'h201, 32'd0, 5'd1);
    tick();
    chk("jalr_target", br_target_out, 32'h200);
    chk("jalr_link", alu_out, 32'h104);
    chk("jalr_taken", {31'd0, br_taken_out}, 32'd1);
    issue({20'h12345, 5'd3, 7'b0110111}, 32'h200, 32'd0, 32'd0, 5'd3);
    tick();
    chk("lui_res", alu_out, 32'h1234_5000);
    issue(32'h0000_0000, 32'h204, 32'd1, 32'd2, 5'd4);
    tick();
    chk("ill_flag", {31'd0, illegal_out}, 32'd1);
    chk("ill_wb_en", {31'd0, wb_en_out}, 32'd0);
    chk("ill_alu", alu_out, 32'd0);

`ifndef RV32_MULDIV_EN
    issue(r_type(7'b0000001, 3'b000), 32'h208, 32'd3, 32'd4, 5'd4);
    #1;
    chk("mul_pending", {31'd0, df_ex_pending}, 32'd0);
    tick();
    chk("mul_vld", {31'd0, out_valid}, 32'd1);
    chk("mul_illegal", {31'd0, illegal_out}, 32'd1);
    chk("mul_wb_en", {31'd0, wb_en_out}, 32'd0);
`endif

    in_valid = 1'b0;
    tick();
    chk("drain_vld", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    issue(r_type(7'h00, 3'b000), 32'h300, 32'd100, 32'd23, 5'd7);
    tick();
    issue(r_type(7'h00, 3'b000), 32'h304, 32'd1, 32'd1, 5'd8);
    for (int i = 0; i < 4; i++) begin
      chk("bp_vld", {31'd0, out_valid}, 32'd1);
      chk("bp_alu", alu_out, 32'd123);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    chk("bp_wbreg", {27'd0, wb_reg_out}, 32'd7);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_next_alu", alu_out, 32'd2);
    chk("bp_next_wbreg", {27'd0, wb_reg_out}, 32'd8);

    issue(j_type(21'h20), 32'h100, 32'd0, 32'd0, 5'd1);
    tick();
    chk("jal_link", alu_out, 32'h104);
    chk("jal_target", br_target_out, 32'h120);
    chk("jal_taken", {31'd0, br_taken_out}, 32'd1);
    issue(r_type(7'h00, 3'b000), 32'h120, 32'd1, 32'd1, 5'd2);
    flush_in = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush_in = 1'b0;
    in_valid = 1'b0;
    chk("flush_vld", {31'd0, out_valid}, 32'd0);
    chk("flush_br", {31'd0, br_taken_out}, 32'd0);

`ifdef RV32_MULDIV_EN
    md_run("div_by0", 3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF);
    md_run("rem_by0", 3'b110, 32'd7, 32'd0, 32'd7);
    md_run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    md_run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    md_run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    md_run("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
    md_run("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    in_valid = 1'b0;
    tick();

    issue(r_type(7'b0000001, 3'b100), 32'h500, 32'd100, 32'd3, 5'd10);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("md_flush_pending", {31'd0, df_ex_pending}, 32'd0);
    chk("md_flush_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 36; i++) begin
      seen = seen | out_valid;
      tick();
    end
    chk("md_flush_no_vld", {31'd0, seen}, 32'd0);

    issue(r_type(7'b0000001, 3'b100), 32'h600, 32'd100, 32'd3, 5'd11);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
`else
    out_ready = 1'b0;
    issue(r_type(7'h00, 3'b000), 32'h600, 32'd2, 32'd2, 5'd11);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_alu", alu_out, 32'd4);
`endif
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_vld", {31'd0, out_valid}, 32'd0);
    chk("arst_alu", alu_out, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_pending", {31'd0, df_ex_pending}, 32'd0);
    chk("arst_wbreg", {27'd0, wb_reg_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
